// File: rtl/pc_fetch.sv
// pc_fetch: PC register and instruction-fetch controller (IDLE/FETCH/VALID/HALTED).
// Define FETCH_TIMEOUT_EN to enable the fetch watchdog that halts with a sticky fetch_err.
module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] npc,
  input  logic        halt,
  input  logic        id_ready,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [29:0] pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALTED} state_t;
  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d, cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        accept, tmo_hit;
`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;
  // Counter idles at zero outside FETCH, so it is clear on every entry to FETCH.
  assign tmo_hit = state_q == FETCH && !imem_rdy && tmo_q == TW'(TIMEOUT - 1);
  always_comb tmo_d = (state_q == FETCH && !imem_rdy) ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk) tmo_q <= rst ? '0 : tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = halt ? HALTED : FETCH;
      FETCH:   state_d = tmo_hit ? HALTED : !imem_rdy ? FETCH : halt ? HALTED : VALID;
      VALID:   state_d = halt ? HALTED : id_ready ? FETCH : VALID;
      default: state_d = HALTED;
    endcase
  end
  always_comb begin
    imem_req = state_q == FETCH;
    if_valid = state_q == VALID;
    halted   = state_q == HALTED;
  end
  always_comb begin
    accept  = state_q == VALID && id_ready;
    pc_d    = accept ? npc : pc_q;
    cnt_d   = cnt_q + {31'd0, accept};
    instr_d = (state_q == FETCH && imem_rdy) ? imem_rdata : instr_q;
    err_d   = err_q | tmo_hit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign fetch_cnt = cnt_q;
  assign fetch_err = err_q;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: table-driven directed checks of pc_fetch plus hand-written watchdog sequences.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst, halt, id_ready, imem_rdy;
  logic [29:0] npc;
  logic [31:0] imem_rdata;
  logic [29:0] pc, imem_addr;
  logic        imem_req, if_valid, halted, fetch_err;
  logic [31:0] if_instr, fetch_cnt;
  int checks = 0, failures = 0;

  pc_fetch #(.RESET_PC(30'h0000_0C00), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .npc(npc), .halt(halt), .id_ready(id_ready),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata), .pc(pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .if_valid(if_valid), .if_instr(if_instr), .halted(halted),
    .fetch_cnt(fetch_cnt), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, halt, idr, rdy;
    logic [31:0] rdata;
    logic [29:0] npc;
    logic [29:0] pc;
    logic        req, vld, hlt;
    logic [31:0] instr, cnt;
  } vec_t;
  vec_t vq[$];

  function automatic void add(logic r, logic h, logic i, logic y, logic [31:0] d, logic [29:0] n,
                              logic [29:0] p, logic q, logic v, logic t, logic [31:0] ins, logic [31:0] c);
    vec_t e;
    e.rst = r; e.halt = h; e.idr = i; e.rdy = y; e.rdata = d; e.npc = n;
    e.pc = p; e.req = q; e.vld = v; e.hlt = t; e.instr = ins; e.cnt = c;
    vq.push_back(e);
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  task automatic drive(logic r, logic h, logic i, logic y, logic [31:0] d, logic [29:0] n);
    rst = r; halt = h; id_ready = i; imem_rdy = y; imem_rdata = d; npc = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; id_ready = 1'b0; imem_rdy = 1'b0; imem_rdata = '0; npc = '0;
    //  rst h idr rdy rdata         npc            pc             req vld hlt instr         cnt
    add(1, 0, 0, 0, 32'h0,        30'h0,        30'h0C00,      0, 0, 0, 32'h0,        0);
    add(0, 0, 1, 1, 32'hA0,       30'h0C01,     30'h0C00,      1, 0, 0, 32'h0,        0);
    add(0, 0, 1, 1, 32'hA0,       30'h0C01,     30'h0C00,      0, 1, 0, 32'hA0,       0);
    add(0, 0, 1, 1, 32'hA1,       30'h0C01,     30'h0C01,      1, 0, 0, 32'hA0,       1);
    add(0, 0, 1, 1, 32'hA1,       30'h0C02,     30'h0C01,      0, 1, 0, 32'hA1,       1);
    add(0, 0, 1, 1, 32'hA2,       30'h0C02,     30'h0C02,      1, 0, 0, 32'hA1,       2);
    add(0, 0, 1, 1, 32'hA2,       30'h0C03,     30'h0C02,      0, 1, 0, 32'hA2,       2);
    add(0, 0, 1, 1, 32'h2408_0005, 30'h0C03,    30'h0C03,      1, 0, 0, 32'hA2,       3);
    add(0, 0, 1, 0, 32'h2408_0005, 30'h0C04,    30'h0C03,      1, 0, 0, 32'hA2,       3);
    add(0, 0, 1, 0, 32'h2408_0005, 30'h0C04,    30'h0C03,      1, 0, 0, 32'hA2,       3);
    add(0, 0, 1, 0, 32'h2408_0005, 30'h0C04,    30'h0C03,      1, 0, 0, 32'hA2,       3);
    add(0, 0, 0, 1, 32'h2408_0005, 30'h1234,    30'h0C03,      0, 1, 0, 32'h2408_0005, 3);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 1, 32'hFFFF_FFFF, 30'h1234,  30'h0C03,      0, 1, 0, 32'h2408_0005, 3);
    add(0, 0, 1, 0, 32'hB0,       30'h1234,     30'h1234,      1, 0, 0, 32'h2408_0005, 4);
    add(0, 1, 0, 0, 32'hB0,       30'h1234,     30'h1234,      1, 0, 0, 32'h2408_0005, 4);
    add(0, 0, 0, 1, 32'hB0,       30'h1234,     30'h1234,      0, 1, 0, 32'hB0,       4);
    add(0, 1, 1, 1, 32'hB1,       30'h1235,     30'h1235,      0, 0, 1, 32'hB0,       5);
    add(0, 0, 1, 1, 32'hB2,       30'h1236,     30'h1235,      0, 0, 1, 32'hB0,       5);
    add(0, 0, 1, 1, 32'hB3,       30'h1237,     30'h1235,      0, 0, 1, 32'hB0,       5);
    add(1, 0, 1, 1, 32'hB3,       30'h1237,     30'h0C00,      0, 0, 0, 32'h0,        0);
    add(0, 0, 1, 1, 32'hC0,       30'h3FFF_FFFF, 30'h0C00,     1, 0, 0, 32'h0,        0);
    add(0, 0, 1, 1, 32'hC0,       30'h3FFF_FFFF, 30'h0C00,     0, 1, 0, 32'hC0,       0);
    add(0, 0, 1, 0, 32'hC1,       30'h3FFF_FFFF, 30'h3FFF_FFFF, 1, 0, 0, 32'hC0,      1);
    add(0, 0, 1, 0, 32'hC1,       30'h0,        30'h3FFF_FFFF, 1, 0, 0, 32'hC0,       1);
    add(1, 0, 1, 0, 32'hC1,       30'h0,        30'h0C00,      0, 0, 0, 32'h0,        0);
    add(0, 1, 0, 0, 32'h0,        30'h0,        30'h0C00,      0, 0, 1, 32'h0,        0);
    add(1, 0, 0, 0, 32'h0,        30'h0,        30'h0C00,      0, 0, 0, 32'h0,        0);
    add(0, 0, 0, 0, 32'h0,        30'h0,        30'h0C00,      1, 0, 0, 32'h0,        0);
    add(0, 1, 0, 1, 32'hD0,       30'h0,        30'h0C00,      0, 0, 1, 32'hD0,       0);
    add(1, 0, 0, 0, 32'h0,        30'h0,        30'h0C00,      0, 0, 0, 32'h0,        0);
    add(0, 0, 0, 1, 32'hE0,       30'h0,        30'h0C00,      1, 0, 0, 32'h0,        0);
    add(0, 0, 0, 1, 32'hE0,       30'h5555,     30'h0C00,      0, 1, 0, 32'hE0,       0);
    add(0, 1, 0, 0, 32'hE1,       30'h5555,     30'h0C00,      0, 0, 1, 32'hE0,       0);
    add(1, 0, 0, 0, 32'h0,        30'h0,        30'h0C00,      0, 0, 0, 32'h0,        0);
    foreach (vq[n]) begin
      drive(vq[n].rst, vq[n].halt, vq[n].idr, vq[n].rdy, vq[n].rdata, vq[n].npc);
      chk($sformatf("v%0d.pc", n), {2'b0, pc}, {2'b0, vq[n].pc});
      chk($sformatf("v%0d.req", n), {31'b0, imem_req}, {31'b0, vq[n].req});
      if (vq[n].req) chk($sformatf("v%0d.addr", n), {2'b0, imem_addr}, {2'b0, vq[n].pc});
      chk($sformatf("v%0d.valid", n), {31'b0, if_valid}, {31'b0, vq[n].vld});
      chk($sformatf("v%0d.halted", n), {31'b0, halted}, {31'b0, vq[n].hlt});
      chk($sformatf("v%0d.instr", n), if_instr, vq[n].instr);
      chk($sformatf("v%0d.cnt", n), fetch_cnt, vq[n].cnt);
      chk($sformatf("v%0d.err", n), {31'b0, fetch_err}, 32'd0);
    end
`ifdef FETCH_TIMEOUT_EN
    // 16 FETCH cycles without rdy: error and halt after the 16th.
    drive(0, 0, 0, 0, 32'h0, 30'h0);
    chk("to.enter", {31'b0, imem_req}, 32'd1);
    for (int k = 1; k < 16; k++) begin
      drive(0, 0, 0, 0, 32'h0, 30'h0);
      chk($sformatf("to.wait%0d", k), {30'b0, imem_req, fetch_err}, 32'd2);
    end
    drive(0, 0, 0, 0, 32'h0, 30'h0);
    chk("to.fire", {29'b0, imem_req, halted, fetch_err}, 32'd3);
    drive(0, 0, 0, 0, 32'h0, 30'h0);
    chk("to.sticky", {29'b0, imem_req, halted, fetch_err}, 32'd3);
    drive(1, 0, 0, 0, 32'h0, 30'h0);
    chk("to.rst", {31'b0, fetch_err}, 32'd0);
    // rdy on the 16th FETCH cycle wins.
    drive(0, 0, 0, 0, 32'h0, 30'h0);
    for (int k = 1; k < 16; k++) drive(0, 0, 0, 0, 32'h0, 30'h0);
    drive(0, 0, 0, 1, 32'hF00D, 30'h0);
    chk("to.late_state", {29'b0, if_valid, halted, fetch_err}, 32'd4);
    chk("to.late_instr", if_instr, 32'hF00D);
`else
    // Watchdog absent: FETCH waits well past 16 cycles.
    drive(0, 0, 0, 0, 32'h0, 30'h0);
    for (int k = 0; k < 40; k++) drive(0, 0, 0, 0, 32'h0, 30'h0);
    chk("nowd.wait", {29'b0, imem_req, halted, fetch_err}, 32'd4);
    drive(0, 0, 0, 1, 32'hF00D, 30'h0);
    chk("nowd.done", {30'b0, if_valid, fetch_err}, 32'd2);
    chk("nowd.instr", if_instr, 32'hF00D);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
